// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI target transceiver.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_slv_state_t;
    localparam int SPI_SYNC_DEFAULT = 2;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with rise/fall pulses on the synchronized level.
module spi_edge_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk_p,
    input  logic i_rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_xcvr.sv
// spi_slave_xcvr: SPI mode-0 target, MSB first, full duplex, with a transmit holding register.
module spi_slave_xcvr
    import spi_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
    input  logic         i_clk_p,
    input  logic         i_rst_n,
    input  logic         i_sclk,
    input  logic         i_cs_n,
    input  logic         i_mosi,
    output logic         o_miso,
    output logic         o_miso_oe,
    input  logic [N-1:0] i_tx_data,
    input  logic         i_tx_valid,
    output logic         o_tx_ready,
    output logic [N-1:0] o_rx_data,
    output logic         o_rx_valid,
    output logic         o_busy,
    output logic         o_abort
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    spi_slv_state_t state;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
    logic sclk_unused, cs_unused, mosi_rise_unused, mosi_fall_unused;
    logic [N-1:0] shift, hr, load_word;
    logic [CW-1:0] cnt;
    logic hr_full, sample_bit, load_pending, wr, consume;
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .i_clk_p(i_clk_p), .i_rst_n(i_rst_n), .d(i_sclk),
        .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .i_clk_p(i_clk_p), .i_rst_n(i_rst_n), .d(i_cs_n),
        .q(cs_unused), .rise(cs_rise), .fall(cs_fall));
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .i_clk_p(i_clk_p), .i_rst_n(i_rst_n), .d(i_mosi),
        .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
    assign wr         = i_tx_valid && !hr_full;
    assign load_word  = hr_full ? hr : '0;
    // A word is taken from HR on frame start and on the falling edge after each completed word.
    assign consume    = (state == LOAD) ||
                        (state == SHIFT && !cs_rise && !sclk_rise && sclk_fall && load_pending);
    assign o_tx_ready = !hr_full;
    assign o_busy     = state != IDLE;
    assign o_miso_oe  = state != IDLE;
    assign o_miso     = (state == SHIFT) && shift[N-1];
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            shift        <= '0;
            hr           <= '0;
            hr_full      <= 1'b0;
            cnt          <= '0;
            sample_bit   <= 1'b0;
            load_pending <= 1'b0;
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_abort      <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            o_abort    <= 1'b0;
            hr_full    <= consume ? wr : (hr_full | wr);
            if (wr) hr <= i_tx_data;
            case (state)
                IDLE: if (cs_fall) state <= LOAD;
                LOAD: begin
                    shift        <= load_word;
                    cnt          <= '0;
                    load_pending <= 1'b0;
                    state        <= cs_rise ? IDLE : SHIFT;
                end
                SHIFT: begin
                    // CS edges take priority over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        state        <= IDLE;
                        o_abort      <= cnt != '0;
                        load_pending <= 1'b0;
                    end else if (sclk_rise) begin
                        sample_bit <= mosi;
                        if (cnt == LAST) begin
                            o_rx_data    <= {shift[N-2:0], mosi};
                            o_rx_valid   <= 1'b1;
                            cnt          <= '0;
                            load_pending <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (load_pending) begin
                            shift        <= load_word;
                            load_pending <= 1'b0;
                        end else begin
                            shift <= {shift[N-2:0], sample_bit};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_xcvr.sv
// tb_spi_slave_xcvr: directed self-checking bench acting as SPI master and local logic.
module tb_spi_slave_xcvr;
    logic       i_clk_p = 0, i_rst_n = 0, i_sclk = 0, i_cs_n = 1, i_mosi = 0;
    logic [7:0] i_tx_data = 0;
    logic       i_tx_valid = 0;
    logic       o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_busy, o_abort;
    logic [7:0] o_rx_data;
    int errors = 0, checks = 0, rx_cnt = 0, ab_cnt = 0, n0 = 0, a0 = 0;
    logic [7:0] rx_log [0:15];
    logic [7:0] mi, mi2;

    spi_slave_xcvr #(.N(8), .SYNC_STAGES(2)) dut (
        .i_clk_p(i_clk_p), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_cs_n(i_cs_n),
        .i_mosi(i_mosi), .o_miso(o_miso), .o_miso_oe(o_miso_oe),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_busy(o_busy), .o_abort(o_abort));

    always #5 i_clk_p = ~i_clk_p;

    always @(negedge i_clk_p) begin
        if (o_rx_valid) begin
            rx_log[rx_cnt[3:0]] = o_rx_data;
            rx_cnt++;
        end
        if (o_abort) ab_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_hr(input logic [7:0] d);
        @(negedge i_clk_p);
        i_tx_data = d;
        i_tx_valid = 1;
        @(negedge i_clk_p);
        i_tx_valid = 0;
    endtask

    task automatic bits(input logic [7:0] mo, input int n, output logic [7:0] mo_in);
        mo_in = 0;
        for (int i = 7; i > 7 - n; i--) begin
            i_mosi = mo[i];
            #40 i_sclk = 1;
            mo_in[i] = o_miso;
            #80 i_sclk = 0;
            #40;
        end
    endtask

    task automatic cs_low();
        i_cs_n = 0;
        #200;
    endtask

    task automatic cs_high();
        #200 i_cs_n = 1;
        #200;
    endtask

    initial begin
        #23 i_rst_n = 1;
        #20;
        chk("rst_tx_ready", o_tx_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_rx_data", o_rx_data, 0);
        chk("rst_miso_oe", o_miso_oe, 0);

        // SCLK activity with CS high must be ignored
        repeat (4) begin
            #80 i_sclk = 1;
            #80 i_sclk = 0;
        end
        #100;
        chk("idle_oe", o_miso_oe, 0);
        chk("idle_rx_cnt", rx_cnt, 0);
        chk("idle_tx_ready", o_tx_ready, 1);
        chk("idle_busy", o_busy, 0);

        // full-duplex single word
        write_hr(8'hA5);
        #1 chk("wr_tx_ready_low", o_tx_ready, 0);
        n0 = rx_cnt;
        cs_low();
        chk("frame_busy", o_busy, 1);
        chk("frame_oe", o_miso_oe, 1);
        chk("consumed_tx_ready", o_tx_ready, 1);
        bits(8'h3C, 8, mi);
        chk("fd_miso", mi, 8'hA5);
        cs_high();
        chk("fd_rx_data", o_rx_data, 8'h3C);
        chk("fd_rx_pulses", rx_cnt - n0, 1);
        chk("fd_no_abort", ab_cnt, 0);
        chk("fd_busy_end", o_busy, 0);
        chk("fd_oe_end", o_miso_oe, 0);

        // back-to-back words within one frame
        write_hr(8'h81);
        n0 = rx_cnt;
        cs_low();
        chk("b2b_ready", o_tx_ready, 1);
        write_hr(8'h7E);
        bits(8'h11, 8, mi);
        bits(8'h22, 8, mi2);
        cs_high();
        chk("b2b_miso0", mi, 8'h81);
        chk("b2b_miso1", mi2, 8'h7E);
        chk("b2b_pulses", rx_cnt - n0, 2);
        chk("b2b_rx0", rx_log[n0[3:0]], 8'h11);
        chk("b2b_rx1", rx_log[n0[3:0] + 4'd1], 8'h22);
        chk("b2b_ready_end", o_tx_ready, 1);

        // underrun: HR empty
        n0 = rx_cnt;
        cs_low();
        bits(8'hFF, 8, mi);
        cs_high();
        chk("ur_miso", mi, 8'h00);
        chk("ur_rx_data", o_rx_data, 8'hFF);
        chk("ur_pulses", rx_cnt - n0, 1);

        // abort after 5 bits, then a clean frame
        n0 = rx_cnt;
        a0 = ab_cnt;
        cs_low();
        bits(8'hC3, 5, mi);
        cs_high();
        chk("ab_pulse", ab_cnt - a0, 1);
        chk("ab_no_rx", rx_cnt - n0, 0);
        chk("ab_rx_data_kept", o_rx_data, 8'hFF);
        cs_low();
        bits(8'h55, 8, mi);
        cs_high();
        chk("ab_next_rx", o_rx_data, 8'h55);
        chk("ab_next_pulses", rx_cnt - n0, 1);
        chk("ab_next_no_abort", ab_cnt - a0, 1);

        // reset mid-frame
        write_hr(8'hF0);
        n0 = rx_cnt;
        a0 = ab_cnt;
        cs_low();
        bits(8'h96, 3, mi);
        i_rst_n = 0;
        #1;
        chk("rm_busy", o_busy, 0);
        chk("rm_oe", o_miso_oe, 0);
        chk("rm_miso", o_miso, 0);
        chk("rm_tx_ready", o_tx_ready, 1);
        chk("rm_rx_data", o_rx_data, 0);
        chk("rm_rx_valid", o_rx_valid, 0);
        chk("rm_abort", o_abort, 0);
        i_cs_n = 1;
        #50 i_rst_n = 1;
        #200;
        chk("rm_no_pulses", (rx_cnt - n0) + (ab_cnt - a0), 0);
        chk("rm_idle_busy", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
